// File: rtl/note_sequencer.sv
// Single-voice note sequencer: accepts (index, length) note commands, fetches the
// half-period code from the frequency table and plays a square wave for len beats.
module note_sequencer #(
    parameter int TONE_DIV = 16,
    parameter int BEAT_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       note_valid,
    input  logic [3:0] note_idx,
    input  logic [3:0] note_len,
    output logic       note_ready,
    input  logic       stop,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       tone_out,
    output logic       busy,
    output logic       note_done
);

    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int BW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [TW-1:0] TONE_MAX = TW'(TONE_DIV - 1);
    localparam logic [TW-1:0] TONE_ONE = TW'(1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(BEAT_DIV - 1);
    localparam logic [BW-1:0] BEAT_ONE = BW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            accept_s;
    logic            ready_s;
    logic            tone_tick_s;
    logic            beat_tick_s;
    logic [3:0]      rom_addr_r;
    logic [3:0]      len_r;
    logic [7:0]      period_r;
    logic [7:0]      half_r;
    logic [TW-1:0]   tone_cnt_r;
    logic [BW-1:0]   beat_cnt_r;
    logic            tone_r;
    logic            done_r;

    // Next-state decode, handshake and prescaler wrap detection
    always_comb begin
        state_s     = state_r;
        ready_s     = (state_r == IDLE) && !stop && !rst;
        accept_s    = note_valid && ready_s;
        tone_tick_s = (tone_cnt_r == TONE_MAX);
        beat_tick_s = (beat_cnt_r == BEAT_MAX);
        if (stop) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && (note_len != 4'd0)) begin
                        state_s = FETCH;
                    end else begin
                        state_s = IDLE;
                    end
                end
                FETCH: state_s = PLAY;
                PLAY: begin
                    if (beat_tick_s && (len_r == 4'd1)) begin
                        state_s = IDLE;
                    end else begin
                        state_s = PLAY;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: command capture, period fetch, tone/beat prescalers and output
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_r <= 4'd0;
            len_r      <= 4'd0;
            period_r   <= 8'd0;
            half_r     <= 8'd0;
            tone_cnt_r <= '0;
            beat_cnt_r <= '0;
            tone_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (stop) begin
            len_r      <= 4'd0;
            half_r     <= 8'd0;
            tone_cnt_r <= '0;
            beat_cnt_r <= '0;
            tone_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    tone_r <= 1'b0;
                    if (accept_s) begin
                        rom_addr_r <= note_idx;
                        len_r      <= note_len;
                    end
                end
                FETCH: begin
                    period_r   <= rom_data;
                    half_r     <= rom_data;
                    tone_cnt_r <= '0;
                    beat_cnt_r <= '0;
                    tone_r     <= 1'b0;
                end
                PLAY: begin
                    tone_cnt_r <= tone_tick_s ? '0 : (tone_cnt_r + TONE_ONE);
                    beat_cnt_r <= beat_tick_s ? '0 : (beat_cnt_r + BEAT_ONE);
                    // A zero period is a rest: the half counter is left alone and no toggles occur
                    if (tone_tick_s && (period_r != 8'd0)) begin
                        if (half_r == 8'd1) begin
                            tone_r <= ~tone_r;
                            half_r <= period_r;
                        end else begin
                            half_r <= half_r - 8'd1;
                        end
                    end
                    // Note end overrides any toggle on the same edge so IDLE starts with tone low
                    if (beat_tick_s) begin
                        if (len_r == 4'd1) begin
                            len_r  <= 4'd0;
                            tone_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            len_r <= len_r - 4'd1;
                        end
                    end
                end
                default: begin
                    tone_r <= 1'b0;
                end
            endcase
        end
    end

    assign note_ready = ready_s;
    assign rom_addr   = rom_addr_r;
    assign tone_out   = tone_r;
    assign busy       = (state_r != IDLE);
    assign note_done  = done_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: a cycle-schedule model of each note
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_note_sequencer;

    localparam int TD = 2;
    localparam int BD = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       note_valid = 1'b0;
    logic [3:0] note_idx = 4'd0;
    logic [3:0] note_len = 4'd0;
    logic       note_ready;
    logic       stop = 1'b0;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       tone_out;
    logic       busy;
    logic       note_done;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    note_sequencer #(.TONE_DIV(TD), .BEAT_DIV(BD)) dut (
        .clk(clk), .rst(rst), .note_valid(note_valid), .note_idx(note_idx),
        .note_len(note_len), .note_ready(note_ready), .stop(stop),
        .rom_addr(rom_addr), .rom_data(rom_data), .tone_out(tone_out),
        .busy(busy), .note_done(note_done)
    );

    function automatic logic [7:0] rom_lookup(input logic [3:0] a);
        case (a)
            4'd0: rom_lookup = 8'd5;
            4'd1: rom_lookup = 8'd86;
            4'd2: rom_lookup = 8'h4D;
            4'd3: rom_lookup = 8'd68;
            4'd4: rom_lookup = 8'd64;
            4'd5: rom_lookup = 8'd57;
            4'd6: rom_lookup = 8'd51;
            4'd8: rom_lookup = 8'd45;
            4'd9: rom_lookup = 8'd72;
            default: rom_lookup = 8'd0;
        endcase
    endfunction

    assign rom_data = rom_lookup(rom_addr);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Model: each accepted note is a schedule of cycle numbers
    int   m_valid = 0;
    int   b_from = 0;
    int   b_until = 0;
    int   p_start = 0;
    int   m_code = 0;
    int   done_at = -1;
    logic [3:0] m_addr = 4'd0;

    always @(negedge clk) begin
        logic e_busy, e_tone, e_done, e_ready;
        int   rel;
        e_busy  = (cyc >= b_from) && (cyc < b_until);
        rel     = cyc - p_start;
        e_tone  = e_busy && (cyc >= p_start) && (m_code != 0) && (((rel / (m_code * TD)) % 2) == 1);
        e_done  = (cyc == done_at);
        e_ready = !e_busy && !stop && !rst;
        if (m_valid != 0) begin
            check("m_ready", 32'(note_ready), 32'(e_ready));
            check("m_busy", 32'(busy), 32'(e_busy));
            check("m_tone", 32'(tone_out), 32'(e_tone));
            check("m_done", 32'(note_done), 32'(e_done));
            check("m_addr", 32'(rom_addr), 32'(m_addr));
        end
        if (rst) begin
            m_valid = 1;
            b_from  = 0;
            b_until = 0;
            done_at = -1;
            m_addr  = 4'd0;
        end else if (stop) begin
            if (e_busy) begin
                b_until = cyc + 1;
                done_at = -1;
            end
        end else if (e_ready && note_valid) begin
            m_addr = note_idx;
            if (note_len != 4'd0) begin
                b_from  = cyc + 1;
                p_start = cyc + 2;
                b_until = p_start + int'(note_len) * BD;
                done_at = b_until;
                m_code  = int'(rom_lookup(note_idx));
            end
        end
    end

    task automatic at_cycle(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic send(input logic [3:0] idx, input logic [3:0] len, input bit keep, output int acc);
        note_idx   = idx;
        note_len   = len;
        note_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (note_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) note_valid = 1'b0;
    endtask

    task automatic count_win(input int n, output int nb, output int nt, output int nd);
        nb = 0; nt = 0; nd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            nb += int'(busy);
            nt += int'(tone_out);
            nd += int'(note_done);
        end
    endtask

    initial begin
        int acc, acc2, ps, ps2, nb, nt, nd;
        rst = 1'b1; note_valid = 1'b1; note_idx = 4'd4; note_len = 4'd1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", 32'(note_ready), 32'd0);
        check("rst_tone", 32'(tone_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; note_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(note_ready), 32'd1);
        check("post_rst_addr", 32'(rom_addr), 32'd0);

        // Tone: code 64, TONE_DIV 2, 400 PLAY cycles
        send(4'd4, 4'd10, 1'b0, acc);
        ps = acc + 2;
        at_cycle(ps - 1);
        check("fetch_busy", 32'(busy), 32'd1);
        check("fetch_addr", 32'(rom_addr), 32'd4);
        at_cycle(ps + 127); check("tone_127", 32'(tone_out), 32'd0);
        at_cycle(ps + 128); check("tone_128", 32'(tone_out), 32'd1);
        at_cycle(ps + 255); check("tone_255", 32'(tone_out), 32'd1);
        at_cycle(ps + 256); check("tone_256", 32'(tone_out), 32'd0);
        at_cycle(ps + 383); check("tone_383", 32'(tone_out), 32'd0);
        at_cycle(ps + 384); check("tone_384", 32'(tone_out), 32'd1);
        at_cycle(ps + 399); check("tone_399", 32'(tone_out), 32'd1);
        at_cycle(ps + 400);
        check("end_busy", 32'(busy), 32'd0);
        check("end_tone", 32'(tone_out), 32'd0);
        check("end_done", 32'(note_done), 32'd1);
        at_cycle(ps + 401); check("done_pulse", 32'(note_done), 32'd0);

        // Rest: index 7, two beats
        send(4'd7, 4'd2, 1'b0, acc);
        count_win(100, nb, nt, nd);
        check("rest_busy_cycles", 32'(nb), 32'(1 + 2 * BD));
        check("rest_tone_high", 32'(nt), 32'd0);
        check("rest_done_count", 32'(nd), 32'd1);

        // Unpopulated index behaves as rest
        send(4'd12, 4'd1, 1'b0, acc);
        count_win(60, nb, nt, nd);
        check("idx12_busy_cycles", 32'(nb), 32'(1 + BD));
        check("idx12_tone_high", 32'(nt), 32'd0);
        check("idx12_done_count", 32'(nd), 32'd1);

        // Zero length: consumed, nothing plays
        send(4'd3, 4'd0, 1'b0, acc);
        count_win(20, nb, nt, nd);
        check("len0_busy", 32'(nb), 32'd0);
        check("len0_done", 32'(nd), 32'd0);
        check("len0_addr", 32'(rom_addr), 32'd3);

        // Abort at PLAY cycle 100, then stop + valid in IDLE
        send(4'd9, 4'd15, 1'b0, acc);
        ps = acc + 2;
        at_cycle(ps + 99);
        @(posedge clk); #1;
        stop = 1'b1;
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        @(posedge clk); #1;
        note_valid = 1'b1; note_idx = 4'd5; note_len = 4'd1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tone", 32'(tone_out), 32'd0);
        check("abort_done", 32'(note_done), 32'd0);
        check("stop_ready", 32'(note_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        stop = 1'b0; note_valid = 1'b0;
        @(negedge clk);
        check("stop_no_accept_addr", 32'(rom_addr), 32'd9);
        check("stop_no_accept_busy", 32'(busy), 32'd0);

        // Back-to-back with valid held
        send(4'd0, 4'd1, 1'b1, acc);
        note_idx = 4'd2; note_len = 4'd5;
        send(4'd2, 4'd5, 1'b0, acc2);
        check("b2b_accept_cycle", 32'(acc2), 32'(acc + 2 + BD));
        ps2 = acc2 + 2;
        at_cycle(ps2 - 1);
        check("b2b_fetch_busy", 32'(busy), 32'd1);
        check("b2b_addr", 32'(rom_addr), 32'd2);
        at_cycle(ps2 + 153); check("b2b_tone_153", 32'(tone_out), 32'd0);
        at_cycle(ps2 + 154); check("b2b_tone_154", 32'(tone_out), 32'd1);
        at_cycle(ps2 + 200);
        check("b2b_end_done", 32'(note_done), 32'd1);
        check("b2b_end_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
